spi_master_ram_ctrl: RTL and testbench

//  SPI master that drives the SPI slave / RAM subsystem from the system clock domain.

---
 rtl/spi_ram_pkg.sv | 33 +++
 rtl/spi_master_ram_ctrl_if.sv | 31 +++
 rtl/spi_sck_gen.sv | 35 +++
 rtl/spi_master_ram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_master_ram_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM link: command encodings, controller
// FSM states and frame geometry. The slave side imports the same package.
package spi_ram_pkg;

  localparam int CMD_W   = 2;
  localparam int FRAME_W = CMD_W + 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_RD_SHIFT,
    ST_HOLD
  } state_e;

  // Data commands are only meaningful after the matching address command.
  function automatic logic cmd_allowed(cmd_e cmd, logic last_vld, cmd_e last_cmd);
    case (cmd)
      CMD_WR_DATA: return last_vld && (last_cmd == CMD_WR_ADDR || last_cmd == CMD_WR_DATA);
      CMD_RD_DATA: return last_vld && (last_cmd == CMD_RD_ADDR);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/spi_master_ram_ctrl_if.sv
// Host request/response handshake plus the four SPI pins of the RAM master.
// master = controller side, slave = host/bench side.
interface spi_master_ram_ctrl_if #(
  parameter int DATA_W = 8
);
  import spi_ram_pkg::*;

  logic              start;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              err;
  logic              SCK;
  logic              SS_n;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  start, cmd, din, MISO,
    output busy, done, rd_data, rd_valid, err, SCK, SS_n, MOSI
  );

  modport slave (
    output start, cmd, din, MISO,
    input  busy, done, rd_data, rd_valid, err, SCK, SS_n, MOSI
  );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK divider: one counter produces a tick every CLK_DIV cycles; SCK toggles on
// ticks while sck_en is high. rise_tick/fall_tick say which way SCK is about to go.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic sck_en,
  output logic sck,
  output logic tick,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick      = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = tick && !sck;
  assign fall_tick = tick && sck;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && sck_en) sck <= ~sck;
    end
  end

endmodule

// File: rtl/spi_master_ram_ctrl.sv
// SPI master for the RAM subsystem: one {cmd,data} frame per start, plus read
// capture for cmd 11. Define SPI_MASTER_CMD_CHECK_EN to reject out-of-order commands.
module spi_master_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int RD_GAP  = 1,
  parameter int DATA_W  = 8
) (
  input logic                   clk,
  input logic                   rst,
  spi_master_ram_ctrl_if.master bus
);
  localparam int FRAME_LEN = CMD_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + DATA_W + RD_GAP + 1);

  state_e               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [DATA_W-1:0]    rx;
  logic [DATA_W-1:0]    rd_data_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic [1:0]           hold_cnt;
  logic                 is_rd, busy_q, done_q, rd_valid_q, ss_n_q;
  logic                 sck, tick, rise_tick, fall_tick;
  logic                 div_en, div_clr, sck_en, accept_ok;

  assign div_en  = (state != ST_IDLE);
  assign div_clr = (state == ST_IDLE);
  assign sck_en  = state inside {ST_SETUP, ST_SHIFT, ST_GAP, ST_RD_SHIFT};

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (div_en),
    .clr       (div_clr),
    .sck_en    (sck_en),
    .sck       (sck),
    .tick      (tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

`ifdef SPI_MASTER_CMD_CHECK_EN
  cmd_e last_cmd;
  logic last_vld;
  logic err_q;

  assign accept_ok = cmd_allowed(cmd_e'(bus.cmd), last_vld, last_cmd);
  assign bus.err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_vld <= 1'b0;
      last_cmd <= CMD_WR_ADDR;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state == ST_IDLE && bus.start) begin
        if (accept_ok) begin
          last_vld <= 1'b1;
          last_cmd <= cmd_e'(bus.cmd);
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end
`else
  assign accept_ok = 1'b1;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      rx         <= '0;
      rd_data_q  <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      is_rd      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && accept_ok) begin
            shreg   <= {bus.cmd, bus.din};
            is_rd   <= (bus.cmd == CMD_RD_DATA);
            bit_cnt <= '0;
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: if (tick) state <= ST_SHIFT;
        ST_SHIFT: begin
          if (fall_tick) begin
            shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
            if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
              bit_cnt  <= '0;
              hold_cnt <= '0;
              state    <= !is_rd ? ST_HOLD : (RD_GAP > 0) ? ST_GAP : ST_RD_SHIFT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (fall_tick) begin
            if (bit_cnt == CNT_W'(RD_GAP - 1)) begin
              bit_cnt <= '0;
              state   <= ST_RD_SHIFT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_RD_SHIFT: begin
          if (rise_tick) rx <= {rx[DATA_W-2:0], bus.MISO};
          if (fall_tick) begin
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt  <= '0;
              hold_cnt <= '0;
              state    <= ST_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Tick 1 ends the last low half-period and releases SS_n, so SS_n is
          // already high for CLK_DIV cycles when a back-to-back start arrives.
          if (hold_cnt == 2'd2) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (is_rd) begin
              rd_data_q  <= rx;
              rd_valid_q <= 1'b1;
            end
            state <= ST_IDLE;
          end else if (tick) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == 2'd0) ss_n_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.SCK      = sck;
  assign bus.SS_n     = ss_n_q;
  assign bus.MOSI     = shreg[FRAME_LEN-1];

endmodule

// File: tb/tb_spi_master_ram_ctrl.sv
// Bench for spi_master_ram_ctrl (CLK_DIV=2, RD_GAP=1) with an SPI slave + RAM model.
// Build with SPI_MASTER_CMD_CHECK_EN defined to exercise the command-order check.
module tb_spi_master_ram_ctrl;
  localparam int TB_CLK_DIV = 2;
  localparam int TB_RD_GAP  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_ram_ctrl_if #(.DATA_W(8)) bus ();

  spi_master_ram_ctrl #(.CLK_DIV(TB_CLK_DIV), .RD_GAP(TB_RD_GAP), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave + RAM model: sample MOSI on SCK rise, drive MISO on SCK fall.
  logic [7:0] ram [256];
  logic [7:0] s_addr = 8'h00, rd_byte = 8'h00;
  logic [9:0] frame_bits = '0, last_frame = '0;
  logic       sck_q = 1'b0, miso_r = 1'b0;
  int         nrise = 0, nfall = 0, last_pulses = -1, err_cnt = 0;

  assign bus.MISO = miso_r;

  always @(negedge clk) begin
    if (bus.err === 1'b1) err_cnt++;
    if (bus.SS_n !== 1'b0) begin
      if (nrise != 0) begin
        last_pulses = nrise;
        last_frame  = frame_bits;
      end
      nrise = 0; nfall = 0; sck_q = 1'b0; miso_r = 1'b0;
    end else begin
      if (bus.SCK && !sck_q) begin
        nrise++;
        if (nrise <= 10) frame_bits = {frame_bits[8:0], bus.MOSI};
        if (nrise == 10) begin
          case (frame_bits[9:8])
            2'b00: s_addr = frame_bits[7:0];
            2'b01: ram[s_addr] = frame_bits[7:0];
            2'b10: s_addr = frame_bits[7:0];
            default: rd_byte = ram[s_addr];
          endcase
        end
      end
      if (!bus.SCK && sck_q) begin
        nfall++;
        if (frame_bits[9:8] == 2'b11 && nfall >= 10 + TB_RD_GAP && nfall <= 17 + TB_RD_GAP)
          miso_r = rd_byte[7 - (nfall - 10 - TB_RD_GAP)];
      end
      sck_q = bus.SCK;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic run_frame(input logic [1:0] c, input logic [7:0] d, output int done_edge,
                           output logic busy_ok, output logic rdv, output logic [7:0] rdd);
    done_edge = -1; busy_ok = 1'b1; rdv = 1'b0; rdd = 8'h00;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = c; bus.din = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        done_edge = k; rdv = bus.rd_valid; rdd = bus.rd_data;
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] din;
    int         exp_edge;
    int         exp_pulses;
    logic       exp_rdv;
    logic [7:0] exp_rdd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int         de, d1, d2, acc2, hi, dn;
    logic       bok, rdv;
    logic [7:0] rdd;

    vecs[0]  = '{2'b00, 8'hA5, 45, 10, 1'b0, 8'h00};
    vecs[1]  = '{2'b00, 8'h10, 45, 10, 1'b0, 8'h00};
    vecs[2]  = '{2'b01, 8'h3C, 45, 10, 1'b0, 8'h00};
    vecs[3]  = '{2'b10, 8'h10, 45, 10, 1'b0, 8'h00};
    vecs[4]  = '{2'b11, 8'h00, 81, 19, 1'b1, 8'h3C};
    vecs[5]  = '{2'b00, 8'h20, 45, 10, 1'b0, 8'h3C};
    vecs[6]  = '{2'b01, 8'hC3, 45, 10, 1'b0, 8'h3C};
    vecs[7]  = '{2'b10, 8'h20, 45, 10, 1'b0, 8'h3C};
    vecs[8]  = '{2'b11, 8'hFF, 81, 19, 1'b1, 8'hC3};
    vecs[9]  = '{2'b10, 8'h10, 45, 10, 1'b0, 8'hC3};
    vecs[10] = '{2'b11, 8'h5A, 81, 19, 1'b1, 8'h3C};

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    bus.start = 1'b0; bus.cmd = 2'b00; bus.din = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({bus.SCK, bus.SS_n, bus.MOSI, bus.busy, bus.done, bus.rd_valid, bus.err, bus.rd_data}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_frame(vecs[i].cmd, vecs[i].din, de, bok, rdv, rdd);
      check($sformatf("v%0d_done_edge", i), 32'(de), 32'(vecs[i].exp_edge));
      check($sformatf("v%0d_busy", i), 32'(bok), 32'(1'b1));
      check($sformatf("v%0d_pulses", i), 32'(last_pulses), 32'(vecs[i].exp_pulses));
      check($sformatf("v%0d_mosi_frame", i), 32'(last_frame), 32'({vecs[i].cmd, vecs[i].din}));
      check($sformatf("v%0d_rd_valid", i), 32'(rdv), 32'(vecs[i].exp_rdv));
      check($sformatf("v%0d_rd_data", i), 32'(rdd), 32'(vecs[i].exp_rdd));
      repeat (3) @(posedge clk);
    end
    check("ram_16", 32'(ram[8'h10]), 32'(8'h3C));

    // start pulsed mid-frame must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 2'b00; bus.din = 8'h77;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dn = 0; de = -1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (k == 10) begin bus.start = 1'b1; bus.cmd = 2'b01; bus.din = 8'hEE; end
      else bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin dn++; de = k; end
    end
    check("busy_ign_done_count", 32'(dn), 32'd1);
    check("busy_ign_done_edge", 32'(de), 32'd45);
    check("busy_ign_pulses", 32'(last_pulses), 32'd10);
    check("busy_ign_frame", 32'(last_frame), 32'({2'b00, 8'h77}));

    // start held high: second frame accepted in the done cycle
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 2'b00; bus.din = 8'h5A;
    @(posedge clk); #1;
    d1 = -1; d2 = -1; acc2 = -1; hi = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (d1 < 0) d1 = k;
        else begin d2 = k; break; end
      end else if (d1 >= 0 && acc2 < 0 && bus.busy) begin
        acc2 = k;
        bus.start = 1'b0;
      end
      if (acc2 < 0 && bus.SS_n) hi++;
    end
    check("b2b_first_done", 32'(d1), 32'd45);
    check("b2b_accept_edge", 32'(acc2), 32'd46);
    check("b2b_ss_high_gap", 32'(hi >= TB_CLK_DIV), 32'd1);
    check("b2b_second_done", 32'(d2), 32'd91);
    check("b2b_pulses", 32'(last_pulses), 32'd10);
    repeat (3) @(posedge clk);

    // synchronous reset at edge 20 of a write frame
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 2'b00; bus.din = 8'h33;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs",
          32'({bus.SS_n, bus.SCK, bus.busy, bus.MOSI, bus.done, bus.rd_data}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    @(negedge clk) rst = 1'b0;
    dn = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    check("midrst_no_done", 32'(dn), 32'd0);

`ifdef SPI_MASTER_CMD_CHECK_EN
    // out-of-order commands straight after reset are dropped with an err pulse
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.cmd = (j == 0) ? 2'b11 : 2'b01; bus.din = 8'h00;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check($sformatf("chk%0d_err_pulse", j), 32'({bus.err, bus.SS_n, bus.busy}),
            32'({1'b1, 1'b1, 1'b0}));
      @(posedge clk); #1;
      check($sformatf("chk%0d_err_clear", j), 32'(bus.err), 32'd0);
      dn = 0;
      repeat (100) begin
        @(posedge clk); #1;
        if (bus.done || !bus.SS_n) dn++;
      end
      check($sformatf("chk%0d_no_frame", j), 32'(dn), 32'd0);
    end
    check("err_total", 32'(err_cnt), 32'd2);
`else
    check("err_total", 32'(err_cnt), 32'd0);
`endif

    run_frame(2'b10, 8'h20, de, bok, rdv, rdd);
    check("tail_rd_addr_edge", 32'(de), 32'd45);
    run_frame(2'b11, 8'h00, de, bok, rdv, rdd);
    check("tail_rd_edge", 32'(de), 32'd81);
    check("tail_rd_result", 32'({rdv, rdd}), 32'({1'b1, 8'hC3}));
    @(posedge clk); #1;
    check("tail_rd_valid_pulse", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b0, 8'hC3}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
